// File: rtl/adder_tree_operand_loader_pkg.sv
// rtl/adder_tree_operand_loader_pkg.sv - shared types for the adder tree operand path
package adder_tree_operand_loader_pkg;

  localparam int ADDER_WIDTH_DEFAULT  = 24;
  localparam int NUM_OPERANDS_DEFAULT = 8;

  typedef logic [ADDER_WIDTH_DEFAULT-1:0] operand_t;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } bank_state_e;

  function automatic int count_width(input int num_operands);
    return $clog2(num_operands + 1);
  endfunction

endpackage

// File: rtl/adder_tree_operand_loader_if.sv
// rtl/adder_tree_operand_loader_if.sv - serial operand stream in, packed group out
interface adder_tree_operand_loader_if
  import adder_tree_operand_loader_pkg::*;
#(
  parameter int ADDER_WIDTH  = ADDER_WIDTH_DEFAULT,
  parameter int NUM_OPERANDS = NUM_OPERANDS_DEFAULT,
  parameter int CNT_W        = count_width(NUM_OPERANDS)
);

  logic                                in_valid;
  logic                                in_ready;
  logic [ADDER_WIDTH-1:0]              in_data;
  logic                                in_last;
  logic                                out_valid;
  logic                                out_ready;
  logic [NUM_OPERANDS*ADDER_WIDTH-1:0] out_ops;
  logic [CNT_W-1:0]                    out_count;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_ops, out_count
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_ops, out_count
  );

endinterface

// File: rtl/adder_tree_operand_bank.sv
// rtl/adder_tree_operand_bank.sv - one ping-pong bank: slot storage, state and count
module adder_tree_operand_bank
  import adder_tree_operand_loader_pkg::*;
#(
  parameter int ADDER_WIDTH  = ADDER_WIDTH_DEFAULT,
  parameter int NUM_OPERANDS = NUM_OPERANDS_DEFAULT,
  parameter int CNT_W        = count_width(NUM_OPERANDS),
  parameter int IDX_W        = $clog2(NUM_OPERANDS)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                wr_en,
  input  logic                                wr_close,
  input  logic [IDX_W-1:0]                    wr_idx,
  input  logic [ADDER_WIDTH-1:0]              wr_data,
  input  logic                                clear,
  output bank_state_e                         bank_state,
  output logic [NUM_OPERANDS*ADDER_WIDTH-1:0] data,
  output logic [CNT_W-1:0]                    count
);

  logic [NUM_OPERANDS-1:0][ADDER_WIDTH-1:0] slots;

  assign data = slots;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slots      <= '0;
      bank_state <= EMPTY;
      count      <= '0;
    end else if (clear) begin
      slots      <= '0;
      bank_state <= EMPTY;
      count      <= '0;
    end else if (wr_en) begin
      for (int k = 0; k < NUM_OPERANDS; k++) begin
        if (k == int'(wr_idx)) begin
          slots[k] <= wr_data;
        end else if (wr_close && (k > int'(wr_idx))) begin
          // Early close zero-pads the tail so the tree sees clean leaves
          slots[k] <= '0;
        end
      end
      if (wr_close) begin
        bank_state <= FULL;
        count      <= CNT_W'(wr_idx) + CNT_W'(1);
      end else begin
        bank_state <= FILLING;
      end
    end
  end

endmodule

// File: rtl/adder_tree_operand_loader.sv
// rtl/adder_tree_operand_loader.sv - packs a serial operand stream into groups for the adder tree
module adder_tree_operand_loader
  import adder_tree_operand_loader_pkg::*;
#(
  parameter int ADDER_WIDTH  = ADDER_WIDTH_DEFAULT,
  parameter int NUM_OPERANDS = NUM_OPERANDS_DEFAULT,
  parameter int CNT_W        = count_width(NUM_OPERANDS)
) (
  input logic                        clk,
  input logic                        rst_n,
  adder_tree_operand_loader_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_OPERANDS);
  localparam int OPS_W = NUM_OPERANDS * ADDER_WIDTH;

  logic             ready_q;
  logic             wr_bank;
  logic             rd_bank;
  logic [IDX_W-1:0] fill_idx;

  bank_state_e      bank_state [2];
  logic [OPS_W-1:0] bank_data  [2];
  logic [CNT_W-1:0] bank_count [2];

  logic beat;
  logic last_slot;
  logic close;
  logic drain;

  // ready_q holds in_ready low until the first edge out of reset
  assign bus.in_ready  = ready_q && (bank_state[wr_bank] != FULL);
  assign bus.out_valid = (bank_state[rd_bank] == FULL);
  assign bus.out_ops   = bank_data[rd_bank];
  assign bus.out_count = bank_count[rd_bank];

  assign beat      = bus.in_valid && bus.in_ready;
  assign last_slot = (fill_idx == IDX_W'(NUM_OPERANDS - 1));
  assign close     = beat && (bus.in_last || last_slot);
  assign drain     = bus.out_valid && bus.out_ready;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    adder_tree_operand_bank #(
      .ADDER_WIDTH (ADDER_WIDTH),
      .NUM_OPERANDS(NUM_OPERANDS),
      .CNT_W       (CNT_W),
      .IDX_W       (IDX_W)
    ) u_bank (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en     (beat && (wr_bank == 1'(b))),
      .wr_close  (close),
      .wr_idx    (fill_idx),
      .wr_data   (bus.in_data),
      .clear     (drain && (rd_bank == 1'(b))),
      .bank_state(bank_state[b]),
      .data      (bank_data[b]),
      .count     (bank_count[b])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q  <= 1'b0;
      wr_bank  <= 1'b0;
      rd_bank  <= 1'b0;
      fill_idx <= '0;
    end else begin
      ready_q <= 1'b1;
      if (beat) begin
        if (close) begin
          fill_idx <= '0;
          wr_bank  <= ~wr_bank;
        end else begin
          fill_idx <= fill_idx + IDX_W'(1);
        end
      end
      if (drain) begin
        rd_bank <= ~rd_bank;
      end
    end
  end

endmodule

// File: doc/adder_tree_operand_loader.md
Name: adder_tree_operand_loader

Overview:
- Producer-side companion to the 8-input adder tree. It accepts a serial operand stream over a valid/ready handshake and packs the operands into groups of NUM_OPERANDS.
- Each complete group is presented in parallel, with a valid/ready handshake, to the tree's operand inputs.
- Two ping-pong banks allow one group to fill while the other drains, so the stream runs at one operand per cycle.

Parameters:
- ADDER_WIDTH, 24, width of each operand in bits.
- NUM_OPERANDS, 8, operands per group (tree leaf count); must be a power of 2 and at least 2.
- CNT_W, $clog2(NUM_OPERANDS+1), width of the group-count field (derived; do not override).

Ports:
- clk  input  1  rising-edge clock, the only clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  an operand beat is offered.
- in_ready  output  1  loader can accept a beat this cycle.
- in_data  input  ADDER_WIDTH  operand value.
- in_last  input  1  this beat closes the current group early; the remaining slots are zero-padded.
- out_valid  output  1  a complete group is presented.
- out_ready  input  1  tree side accepts the group this cycle.
- out_ops  output  NUM_OPERANDS*ADDER_WIDTH  packed group; slot k is bits [k*ADDER_WIDTH +: ADDER_WIDTH]; slot 0 is the first beat accepted.
- out_count  output  CNT_W  number of real (non-padded) operands in the group, 1..NUM_OPERANDS.

Behaviour:
- Interface: clk is the single clock; rst_n is asynchronous, active-low.
- Reset values: both banks EMPTY, all bank storage zero, wr_bank=0, rd_bank=0, fill index=0.
  - Outputs under reset: in_ready=0, out_valid=0, out_ops=0, out_count=0.
  - in_ready rises on the first clk edge after rst_n deasserts.
- Handshakes: a beat transfers when in_valid && in_ready at a rising edge. A group transfers when out_valid && out_ready.
- Per-bank state machine: EMPTY -> FILLING -> FULL -> EMPTY.
  - EMPTY -> FILLING on the first beat written to the bank.
  - FILLING -> FULL when the beat written is at index NUM_OPERANDS-1, or the beat has in_last=1.
  - FULL -> EMPTY on the output handshake when the bank is rd_bank.
- Write side:
  - A beat writes in_data to slot [fill index] of wr_bank, then the fill index increments.
  - On the FULL transition: bank count := fill index+1, unwritten slots cleared to 0, fill index := 0, wr_bank toggles.
  - in_ready = (bank[wr_bank] != FULL). It is registered-state based and combinationally independent of out_ready.
- Read side:
  - out_valid = (bank[rd_bank] == FULL).
  - out_ops and out_count come straight from the rd_bank storage and are held stable while out_valid && !out_ready.
  - On the handshake, rd_bank toggles and the drained bank is cleared to zero.
- Latency: the beat that completes a group at edge t gives out_valid=1 after edge t (visible in cycle t+1).
- Throughput: with out_ready held 1, in_ready never drops, giving 1 operand/cycle sustained.
- Backpressure: once both banks are FULL, in_ready=0. It returns to 1 the cycle after the next output handshake.
- Simultaneous events:
  - Completing a bank and draining the other bank in the same edge are both honoured.
  - A bank cannot be completed and drained in the same edge, because out_valid is registered state.
- in_last on the beat at index NUM_OPERANDS-1 behaves the same as a normal full group (count=NUM_OPERANDS).
- in_last is ignored when in_valid=0. in_data is don't-care when in_valid=0.
- Mid-operation reset discards partial and full groups. out_valid drops asynchronously and no stale group is emitted after reset.
- No arithmetic on operands: values pass through bit-exact. out_count saturates structurally at NUM_OPERANDS.

Decomposition:
- Shared package: ADDER_WIDTH default constant, operand_t typedef (logic [ADDER_WIDTH-1:0]), bank_state_e enum {EMPTY, FILLING, FULL}. The tree side imports the same package.
- One sub-module: adder_tree_operand_bank.
  - Holds one bank: slot storage, state, count.
  - Provides write, close and clear controls.
  - Instantiated twice by the top level, which owns wr_bank, rd_bank and the fill index.

Test Plan:
- Full-rate stream: 16 beats with values 1..16, out_ready=1.
  - Group 0 = slots 1..8, count=8; group 1 = slots 9..16, count=8.
  - in_ready stays 1 throughout; each out_valid appears one cycle after the 8th beat.
- Early close: beats 0x000A, 0x000B, 0x000C, the last with in_last=1.
  - Output group = {A,B,C,0,0,0,0,0}, count=3.
  - The next group starts at slot 0.
- Backpressure: out_ready=0 while 24 beats are offered.
  - Exactly 16 beats are accepted, then in_ready=0 and out_ops stays stable.
  - Raising out_ready for 1 cycle drains group 0 and in_ready returns the next cycle.
- Boundary values: beats 0xFFFFFF and 0x000000 alternated, a full group.
  - out_ops bit-exact, slot 0 = 0xFFFFFF, count=8.
- Async reset: assert rst_n low mid-group (after 5 beats) and with one bank FULL.
  - All outputs go to 0 immediately.
  - After release, 8 new beats 0x100..0x107 produce exactly one group containing only those values.
- in_last on the 8th beat: count=8, no extra empty group emitted.
